// File: rtl/aes128_iter_core_pkg.sv
// AES-128 shared types and helpers: S-box, xtime, word ops, FSM encoding.
// Latency: n/a (pure functions and constants).
// Backpressure: n/a.
package aes128_iter_core_pkg;

  localparam int         AES_NR = 10;
  localparam logic [7:0] RCON1  = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_t;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // Entry b sits at bit offset 8*(255-b), and 255-b is ~b for a byte.
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes128_iter_core_if.sv
// Block in/out handshake bundle for the AES-128 iterative core.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the input and the result side.
interface aes128_iter_core_if #(
  parameter int TAG_W = 8
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [127:0]     DIN;
  logic [127:0]     KEY;
  logic [TAG_W-1:0] TAG_IN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [127:0]     DOUT;
  logic [TAG_W-1:0] TAG_OUT;

  // Upstream/downstream side (DMA FIFO feeding, packer draining).
  modport master (
    output IN_VALID, DIN, KEY, TAG_IN, OUT_READY,
    input  IN_READY, OUT_VALID, DOUT, TAG_OUT
  );

  // Core side.
  modport slave (
    input  IN_VALID, DIN, KEY, TAG_IN, OUT_READY,
    output IN_READY, OUT_VALID, DOUT, TAG_OUT
  );
endinterface

// File: rtl/aes128_round_unit.sv
// One AES-128 encrypt round plus the matching on-the-fly key-schedule step.
// Latency: combinational.
// Backpressure: none; driven entirely by the enclosing core.
module aes128_round_unit
  import aes128_iter_core_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [127:0] next_state,
  output logic [127:0] next_rk
);

  logic [31:0]  w0, w1, w2, w3, tmp;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] mixed;

  // Key schedule: next four words from the previous round key and this round's rcon.
  assign w0  = rk[127:96];
  assign w1  = rk[95:64];
  assign w2  = rk[63:32];
  assign w3  = rk[31:0];
  assign tmp = sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
  assign n0  = w0 ^ tmp;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // SubBytes, ShiftRows, MixColumns (skipped on the final round); byte i is row i%4, column i/4.
  always_comb begin
    sb    = '{default: 8'h00};
    sr    = '{default: 8'h00};
    mc    = '{default: 8'h00};
    mixed = '0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state[8*(15-i) +: 8]);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[r+4*c] = sb[r+4*((c+r)%4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      mixed[8*(15-i) +: 8] = last ? sr[i] : mc[i];
    end
  end

  // AddRoundKey uses the freshly expanded key for this round.
  assign next_state = mixed ^ next_rk;

endmodule

// File: rtl/aes128_iter_core.sv
// AES-128 encrypt core, RPC chained rounds per clock, key expanded on the fly per block.
// Latency: accept cycle to first OUT_VALID cycle is 10/RPC + 1 cycles.
// Backpressure: one block in flight; a held result blocks new input until OUT_READY.
module aes128_iter_core
  import aes128_iter_core_pkg::*;
#(
  parameter int RPC   = 1,
  parameter int TAG_W = 8
) (
  input  logic CLK,
  input  logic RST_N,
  aes128_iter_core_if.slave bus
);

  localparam int N     = (RPC > 0) ? (AES_NR / RPC) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (RPC != 1 && RPC != 2 && RPC != 5 && RPC != 10) begin : g_bad_rpc
    $error("aes128_iter_core: RPC must be 1, 2, 5 or 10");
  end

  aes_fsm_t         fsm;
  logic             started;
  logic             out_vld;
  logic [127:0]     state_q;
  logic [127:0]     rk_q;
  logic [7:0]       rcon_q;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;

  logic             last_pass;
  logic             accept;
  logic [127:0]     state_nxt;
  logic [127:0]     rk_nxt;
  logic [7:0]       rcon_nxt;

  assign last_pass = (cnt == CNT_W'(N - 1));

  // Round chain: each stage feeds state, round key and rcon to the next.
  for (genvar j = 0; j < RPC; j++) begin : g_rnd
    localparam bit IS_LAST = (j == RPC - 1);
    logic [127:0] st_in, rk_in, st_out, rk_out;
    logic [7:0]   rc_in, rc_out;

    if (j == 0) begin : g_first
      assign st_in = state_q;
      assign rk_in = rk_q;
      assign rc_in = rcon_q;
    end else begin : g_next
      assign st_in = g_rnd[j-1].st_out;
      assign rk_in = g_rnd[j-1].rk_out;
      assign rc_in = g_rnd[j-1].rc_out;
    end

    assign rc_out = xtime(rc_in);

    aes128_round_unit u_round (
      .state      (st_in),
      .rk         (rk_in),
      .rcon       (rc_in),
      .last       (last_pass & IS_LAST),
      .next_state (st_out),
      .next_rk    (rk_out)
    );
  end

  assign state_nxt = g_rnd[RPC-1].st_out;
  assign rk_nxt    = g_rnd[RPC-1].rk_out;
  assign rcon_nxt  = g_rnd[RPC-1].rc_out;

  // Ready in IDLE, or in DONE when the held result is being taken this same cycle.
  assign bus.IN_READY  = started & ((fsm == ST_IDLE) | ((fsm == ST_DONE) & bus.OUT_READY));
  assign accept        = bus.IN_VALID & bus.IN_READY;
  assign bus.OUT_VALID = out_vld;
  assign bus.DOUT      = out_vld ? state_q : 128'd0;
  assign bus.TAG_OUT   = out_vld ? tag_q : '0;

  // Control FSM plus datapath registers; OUT_VALID is registered alongside the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fsm     <= ST_IDLE;
      started <= 1'b0;
      out_vld <= 1'b0;
      state_q <= '0;
      rk_q    <= '0;
      rcon_q  <= '0;
      cnt     <= '0;
      tag_q   <= '0;
    end else begin
      started <= 1'b1;
      case (fsm)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state_q <= bus.DIN ^ bus.KEY;
            rk_q    <= bus.KEY;
            rcon_q  <= RCON1;
            cnt     <= '0;
            tag_q   <= bus.TAG_IN;
            out_vld <= 1'b0;
            fsm     <= ST_BUSY;
          end else if ((fsm == ST_DONE) && bus.OUT_READY) begin
            out_vld <= 1'b0;
            fsm     <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          state_q <= state_nxt;
          rk_q    <= rk_nxt;
          if (last_pass) begin
            out_vld <= 1'b1;
            fsm     <= ST_DONE;
          end else begin
            cnt    <= cnt + 1'b1;
            rcon_q <= rcon_nxt;
          end
        end
        default: begin
          out_vld <= 1'b0;
          fsm     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
